// File: rtl/cordic_hyp_pkg.sv
// Shared types, iteration schedule and ATANH table
// for the hyperbolic CORDIC sequencer.
package cordic_hyp_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int N_STEPS_DEF = 17;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // step 0..16 -> 1,2,3,4,4,5..13,13,14,15
  function automatic logic [3:0] sched_idx(input logic [4:0] s);
    if (s < 5'd4) return 4'(s + 5'd1);
    if (s < 5'd14) return s[3:0];
    return 4'(s - 5'd1);
  endfunction

  function automatic logic rep_flag(input logic [4:0] s);
    return (s == 5'd4) || (s == 5'd14);
  endfunction

  function automatic logic [15:0] atanh_q(input logic [3:0] i);
    logic [15:0] a;
    a = 16'd0;
    case (i)
      4'd1:  a = 16'd4500;
      4'd2:  a = 16'd2092;
      4'd3:  a = 16'd1029;
      4'd4:  a = 16'd513;
      4'd5:  a = 16'd256;
      4'd6:  a = 16'd128;
      4'd7:  a = 16'd64;
      4'd8:  a = 16'd32;
      4'd9:  a = 16'd16;
      4'd10: a = 16'd8;
      4'd11: a = 16'd4;
      4'd12: a = 16'd2;
      4'd13: a = 16'd1;
      default: a = 16'd0;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/cordic_hyp_seq_rot.sv
// One hyperbolic micro-rotation, purely combinational.
// All three updates are taken from the old x, y, z.
module hyp_micro_rot
  import cordic_hyp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic signed [WIDTH-1:0] z,
  input  logic        [3:0]       i,
  input  logic                    d,
  input  logic                    rep,
  output logic signed [WIDTH-1:0] xn,
  output logic signed [WIDTH-1:0] yn,
  output logic signed [WIDTH-1:0] zn
);

  logic signed [WIDTH-1:0] xs;
  logic signed [WIDTH-1:0] ys;
  logic signed [WIDTH-1:0] at;
  logic                    rep_unused;

  // rep only marks the repeated pass; the arithmetic is the same
  assign rep_unused = rep;

  assign xs = x >>> i;
  assign ys = y >>> i;
  assign at = WIDTH'(atanh_q(i));

  assign xn = d ? x + ys : x - ys;
  assign yn = d ? y + xs : y - xs;
  assign zn = d ? z - at : z + at;

endmodule

// File: rtl/cordic_hyp_seq.sv
// Iterative hyperbolic CORDIC sequencer: FSM, step
// counter and x/y/z registers around hyp_micro_rot.
module cordic_hyp_seq
  import cordic_hyp_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int N_STEPS = N_STEPS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic [WIDTH-1:0] z_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] x_out,
  output logic [WIDTH-1:0] y_out,
  output logic [WIDTH-1:0] z_out,
  output logic             busy
);

  state_t                  state;
  logic [4:0]              step;
  logic                    mode_r;
  logic signed [WIDTH-1:0] xr;
  logic signed [WIDTH-1:0] yr;
  logic signed [WIDTH-1:0] zr;
  logic signed [WIDTH-1:0] xn;
  logic signed [WIDTH-1:0] yn;
  logic signed [WIDTH-1:0] zn;
  logic [3:0]              idx;
  logic                    rp;
  logic                    d;

  assign idx = sched_idx(step);
  assign rp  = rep_flag(step);
  // d=1 means +1: drive z to 0 or y to 0
  assign d   = mode_r ? yr[WIDTH-1] : ~zr[WIDTH-1];

  hyp_micro_rot #(.WIDTH(WIDTH)) u_rot (
    .x  (xr),
    .y  (yr),
    .z  (zr),
    .i  (idx),
    .d  (d),
    .rep(rp),
    .xn (xn),
    .yn (yn),
    .zn (zn)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      step   <= '0;
      mode_r <= 1'b0;
      xr     <= '0;
      yr     <= '0;
      zr     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xr     <= x_in;
            yr     <= y_in;
            zr     <= z_in;
            mode_r <= mode;
            step   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          xr <= xn;
          yr <= yn;
          zr <= zn;
          if (step == 5'(N_STEPS - 1)) state <= DONE;
          else step <= step + 5'd1;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  assign x_out     = xr;
  assign y_out     = yr;
  assign z_out     = zr;

endmodule

// File: tb/tb_cordic_hyp_seq.sv
// Scoreboard bench for cordic_hyp_seq: bit-level model
// plus real-valued spot checks, schedule and handshake.
module tb_cordic_hyp_seq;

  typedef struct {
    int x;
    int y;
    int z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic [15:0] z_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_out;
  logic [15:0] y_out;
  logic [15:0] z_out;
  logic        busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   last_hs = -1;
  int   pos     = 0;
  res_t q[$];

  int sched_exp[17] =
    '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14, 15};

  cordic_hyp_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int obs,
                       input int exp, input int tol = 0);
    n_tests++;
    if (obs - exp > tol || exp - obs > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)",
               tag, obs, exp, tol);
    end
  endtask

  function automatic int wrap16(input int v);
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
  endfunction

  function automatic res_t model(input bit m, input int x0,
                                 input int y0, input int z0);
    int   at[16] = '{0, 4500, 2092, 1029, 513, 256, 128, 64,
                     32, 16, 8, 4, 2, 1, 0, 0};
    int   x, y, z, nx, ny, nz, i;
    bit   dp;
    res_t r;
    x = x0; y = y0; z = z0;
    for (int k = 0; k < 17; k++) begin
      i  = sched_exp[k];
      dp = m ? (y < 0) : (z >= 0);
      if (dp) begin
        nx = x + (y >>> i); ny = y + (x >>> i); nz = z - at[i];
      end else begin
        nx = x - (y >>> i); ny = y - (x >>> i); nz = z + at[i];
      end
      x = wrap16(nx); y = wrap16(ny); z = wrap16(nz);
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  // result monitor: pop on every output handshake
  always @(negedge clk) begin
    res_t e;
    bit   have;
    if (!rst && out_valid && out_ready) begin
      have = (q.size() != 0);
      check("sb_nonempty", int'(have), 1);
      if (have) begin
        e = q.pop_front();
        check("x_out", int'($signed(x_out)), e.x);
        check("y_out", int'($signed(y_out)), e.y);
        check("z_out", int'($signed(z_out)), e.z);
      end
      last_hs = cyc + 1;
    end
  end

  // schedule probe on the micro-rotation instance
  always @(negedge clk) begin
    if (!rst && busy) begin
      if (pos < 17) begin
        check("sched_i", int'(dut.u_rot.i), sched_exp[pos]);
        check("sched_rep", int'(dut.u_rot.rep),
              (pos == 4 || pos == 14) ? 1 : 0);
      end else begin
        check("sched_len", pos, 16);
      end
      pos++;
    end else begin
      pos = 0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  task automatic run_op(input bit m, input int x, input int y,
                        input int z, input bit keep,
                        output int acc);
    bit ok;
    ok = 1'b0;
    acc = -1;
    @(posedge clk); #1;
    mode = m; x_in = 16'(x); y_in = 16'(y); z_in = 16'(z);
    in_valid = 1'b1;
    q.push_back(model(m, x, y, z));
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc + 1;
        ok  = 1'b1;
      end
    end
    check("accept", int'(ok), 1);
    @(posedge clk); #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int v);
    bit ok;
    ok = 1'b0;
    v  = -1;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (out_valid) begin
        v  = cyc;
        ok = 1'b1;
      end
    end
    check("out_valid_seen", int'(ok), 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++)
      @(negedge clk);
    check("drained", q.size(), 0);
  endtask

  initial begin
    int a1, a2, v;
    res_t e;
    rst = 1'b1; in_valid = 1'b0; mode = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_z", int'(z_out), 0);
    rst = 1'b0;

    // rotation: x=1.0, z=0 -> x = Kh
    out_ready = 1'b1;
    run_op(1'b0, 8192, 0, 0, 1'b0, a1);
    wait_valid(v);
    check("latency", v - a1, 17);
    check("rot_x_spec", int'($signed(x_out)), 6784, 8);
    check("rot_y_spec", int'($signed(y_out)), 0, 8);
    check("rot_z_spec", int'($signed(z_out)), 0, 8);

    // vectoring: atanh(0.5)
    run_op(1'b1, 8192, 4096, 0, 1'b0, a1);
    wait_valid(v);
    check("vec_x_spec", int'($signed(x_out)), 5874, 8);
    check("vec_y_spec", int'($signed(y_out)), 0, 8);
    check("vec_z_spec", int'($signed(z_out)), 4500, 8);
    drain();

    // output held while out_ready low; in_valid ignored
    out_ready = 1'b0;
    run_op(1'b0, 4096, 0, 2048, 1'b0, a1);
    repeat (3) @(negedge clk);
    in_valid = 1'b1; x_in = 16'h1234; mode = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(v);
    e = q[0];
    for (int k = 0; k < 10; k++) begin
      check("hold_valid", int'(out_valid), 1);
      check("hold_in_ready", int'(in_ready), 0);
      check("hold_x", int'($signed(x_out)), e.x);
      check("hold_y", int'($signed(y_out)), e.y);
      check("hold_z", int'($signed(z_out)), e.z);
      if (k == 4) in_valid = 1'b1;
      if (k == 6) in_valid = 1'b0;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rel_in_ready", int'(in_ready), 1);
    check("rel_out_valid", int'(out_valid), 0);
    check("rel_drained", q.size(), 0);

    // reset at step 8 abandons the op
    run_op(1'b0, 8192, 0, 4096, 1'b0, a1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_x", int'(x_out), 0);
    check("mid_rst_y", int'(y_out), 0);
    check("mid_rst_z", int'(z_out), 0);
    void'(q.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(1'b1, 6000, -2000, 1000, 1'b0, a1);
    drain();

    // back-to-back with in_valid held high
    run_op(1'b0, 7000, 1000, -3000, 1'b1, a1);
    mode = 1'b1; x_in = 16'd7500; y_in = 16'd2500; z_in = 16'd0;
    q.push_back(model(1'b1, 7500, 2500, 0));
    a2 = -1;
    for (int t = 0; t < 60 && a2 < 0; t++) begin
      @(negedge clk);
      if (in_ready && in_valid) a2 = cyc + 1;
    end
    check("b2b_gap_hs", a2 - last_hs, 1);
    check("b2b_period", a2 - a1, 19);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // a few random operand sets in the convergence range
    for (int k = 0; k < 6; k++) begin
      if (k[0])
        run_op(1'b1, $urandom_range(8000, 6000),
               int'($urandom_range(6000, 0)) - 3000, 0, 1'b0, a1);
      else
        run_op(1'b0, $urandom_range(8000, 4000),
               int'($urandom_range(4000, 0)) - 2000,
               int'($urandom_range(8000, 0)) - 4000, 1'b0, a1);
      drain();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
